// File: rtl/pio_clk_gen.sv
// Avalon-MM PIO that drives a static level or a burst of N clock pulses on out_port; PIO_CLK_GEN_IRQ_EN adds irq.
// Latency: register writes act at the write edge, and a burst starts driving out_port on the following cycle.
// Backpressure: none; zero wait states, and readdata is combinational from address.
module pio_clk_gen #(
  parameter int DIV_W       = 16,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_port,
  output logic        irq
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             data_q, data_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             irq_en;
  logic             irq_en_d;
  logic             wr_en, busy, abort, finish, done_clr;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    div_d    = div_q;
    phase_d  = phase_q;
    rem_d    = rem_q;
    irq_en_d = irq_en;
    finish   = 1'b0;
    wr_en    = chipselect & ~write_n;
    busy     = (state_q != S_IDLE);
    done_clr = wr_en && (address == 2'd3) && writedata[1];
    abort    = wr_en && (address == 2'd3) && writedata[3] && busy;

    if (wr_en && address == 2'd0) data_d = writedata[0];
    if (wr_en && address == 2'd1) div_d = writedata[DIV_W-1:0];
    if (wr_en && address == 2'd3) irq_en_d = writedata[2];

    case (state_q)
      S_IDLE: begin
        if (wr_en && address == 2'd2 && writedata[CNT_W-1:0] != '0) begin
          state_d = S_LOW;
          rem_d   = writedata[CNT_W-1:0];
          phase_d = div_q;
        end
      end
      S_LOW: begin
        if (phase_q == '0) begin
          state_d = S_HIGH;
          phase_d = div_q;
        end else begin
          phase_d = phase_q - DIV_W'(1);
        end
      end
      S_HIGH: begin
        if (phase_q == '0) begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = S_IDLE;
            finish  = 1'b1;
          end else begin
            state_d = S_LOW;
            phase_d = div_q;
          end
        end else begin
          phase_d = phase_q - DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort beats a coincident final expiry, so done is never set by it.
    if (abort) begin
      state_d = S_IDLE;
      rem_d   = '0;
      phase_d = '0;
      finish  = 1'b0;
    end

    // Set wins over a same-edge write-1-to-clear.
    if (finish)        done_d = 1'b1;
    else if (done_clr) done_d = 1'b0;
    else               done_d = done_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      data_q  <= 1'b0;
      div_q   <= DIV_W'(DEFAULT_DIV);
      phase_q <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

`ifdef PIO_CLK_GEN_IRQ_EN
  logic irq_en_q;
  logic irq_q;

  assign irq_en = irq_en_q;
  assign irq    = irq_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= done_d & irq_en_d;
    end
  end
`else
  logic unused_irq_en;

  assign unused_irq_en = irq_en_d;
  assign irq_en        = 1'b0;
  assign irq           = 1'b0;
`endif

  always_comb begin
    case (state_q)
      S_LOW:   out_port = 1'b0;
      S_HIGH:  out_port = 1'b1;
      default: out_port = data_q;
    endcase
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata = {31'd0, data_q};
      2'd1:    readdata = 32'(div_q);
      2'd2:    readdata = 32'(rem_q);
      default: readdata = {28'd0, 1'b0, irq_en, done_q, busy};
    endcase
  end

endmodule

// File: tb/tb_pio_clk_gen.sv
// Directed bench for pio_clk_gen: reset, static level, bursts, ignored writes, abort and done/irq races.
module tb_pio_clk_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        out_port;
  logic        irq;

  int total = 0;
  int bad   = 0;

  pio_clk_gen dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    logic [31:0] exp_rd [4];
    exp_rd = '{32'd0, 32'd24, 32'd0, 32'd0};
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), r);
      total++;
      if (r !== exp_rd[i]) begin
        bad++;
        $display("FAIL reset_read addr%0d: got %0h want %0h", i, r, exp_rd[i]);
      end
    end
    total++;
    if (out_port !== 1'b0) begin
      bad++;
      $display("FAIL reset_out_port: got %b want 0", out_port);
    end
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL reset_irq: got %b want 0", irq);
    end
  endtask

  task automatic test_static();
    logic [31:0] r;
    wr(2'd0, 32'd1);
    total++;
    if (out_port !== 1'b1) begin
      bad++;
      $display("FAIL static_high: got %b want 1", out_port);
    end
    rd(2'd0, r);
    total++;
    if (r !== 32'd1) begin
      bad++;
      $display("FAIL static_read: got %0h want 1", r);
    end
    wr(2'd0, 32'hFFFF_FFFE);
    total++;
    if (out_port !== 1'b0) begin
      bad++;
      $display("FAIL static_low: got %b want 0", out_port);
    end
  endtask

  task automatic test_burst();
    logic [31:0] r;
    logic        exp_pin;
    int          busy_cnt;
    logic [31:0] exp_rem;
    wr(2'd1, 32'd1);
    wr(2'd0, 32'd0);
    wr(2'd2, 32'd3);
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      exp_pin = ((i % 4) >= 2);
      exp_rem = 32'(3 - i / 4);
      total++;
      if (out_port !== exp_pin) begin
        bad++;
        $display("FAIL burst_pin cycle%0d: got %b want %b", i, out_port, exp_pin);
      end
      rd(2'd3, r);
      if (r[0] === 1'b1) busy_cnt++;
      if ((i % 4) == 0 || i == 2) begin
        rd(2'd2, r);
        total++;
        if (r !== exp_rem) begin
          bad++;
          $display("FAIL burst_remaining cycle%0d: got %0d want %0d", i, r, exp_rem);
        end
      end
      if (i == 1) wr(2'd2, 32'd5);
      else        tick();
    end
    rd(2'd3, r);
    if (r[0] === 1'b1) busy_cnt++;
    total++;
    if (busy_cnt != 12) begin
      bad++;
      $display("FAIL burst_busy_cycles: got %0d want 12", busy_cnt);
    end
    total++;
    if (r !== 32'h2) begin
      bad++;
      $display("FAIL burst_status_done: got %0h want 2", r);
    end
    total++;
    if (out_port !== 1'b0) begin
      bad++;
      $display("FAIL burst_idle_pin: got %b want 0", out_port);
    end
    wr(2'd3, 32'h2);
    rd(2'd3, r);
    total++;
    if (r !== 32'h0) begin
      bad++;
      $display("FAIL done_clear: got %0h want 0", r);
    end
    wr(2'd2, 32'h100);
    rd(2'd3, r);
    total++;
    if (r !== 32'h0) begin
      bad++;
      $display("FAIL burst_zero_ignored: got %0h want 0", r);
    end
  endtask

  task automatic test_abort();
    logic [31:0] r;
    wr(2'd1, 32'd3);
    wr(2'd0, 32'd1);
    wr(2'd2, 32'd4);
    for (int i = 0; i < 9; i++) tick();
    total++;
    if (out_port !== 1'b0) begin
      bad++;
      $display("FAIL abort_pre_pin: got %b want 0", out_port);
    end
    wr(2'd3, 32'h8);
    total++;
    if (out_port !== 1'b1) begin
      bad++;
      $display("FAIL abort_pin: got %b want 1", out_port);
    end
    rd(2'd3, r);
    total++;
    if (r !== 32'h0) begin
      bad++;
      $display("FAIL abort_status: got %0h want 0", r);
    end
    rd(2'd2, r);
    total++;
    if (r !== 32'h0) begin
      bad++;
      $display("FAIL abort_remaining: got %0h want 0", r);
    end
    for (int i = 0; i < 20; i++) tick();
    rd(2'd3, r);
    total++;
    if (r !== 32'h0) begin
      bad++;
      $display("FAIL abort_done_stays_low: got %0h want 0", r);
    end
  endtask

  task automatic test_races();
    logic [31:0] r;
    // DIV=3, N=1: eight busy cycles, completion on the edge ending the 8th.
    wr(2'd2, 32'd1);
    for (int i = 0; i < 7; i++) tick();
    wr(2'd3, 32'h2);
    rd(2'd3, r);
    total++;
    if (r !== 32'h2) begin
      bad++;
      $display("FAIL done_set_wins: got %0h want 2", r);
    end
    total++;
    if (out_port !== 1'b1) begin
      bad++;
      $display("FAIL done_race_pin: got %b want 1", out_port);
    end
    wr(2'd3, 32'h2);
    wr(2'd2, 32'd1);
    for (int i = 0; i < 7; i++) tick();
    wr(2'd3, 32'h8);
    rd(2'd3, r);
    total++;
    if (r !== 32'h0) begin
      bad++;
      $display("FAIL abort_wins_final: got %0h want 0", r);
    end
  endtask

  task automatic test_irq();
    logic [31:0] r;
    logic [31:0] exp_en;
    logic        exp_irq;
`ifdef PIO_CLK_GEN_IRQ_EN
    exp_en  = 32'h4;
    exp_irq = 1'b1;
`else
    exp_en  = 32'h0;
    exp_irq = 1'b0;
`endif
    wr(2'd0, 32'd0);
    wr(2'd1, 32'd0);
    wr(2'd3, 32'h4);
    rd(2'd3, r);
    total++;
    if (r !== exp_en) begin
      bad++;
      $display("FAIL irq_en_read: got %0h want %0h", r, exp_en);
    end
    wr(2'd2, 32'd1);
    total++;
    if (out_port !== 1'b0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_cycle1: got pin=%b irq=%b want pin=0 irq=0", out_port, irq);
    end
    tick();
    total++;
    if (out_port !== 1'b1 || irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_cycle2: got pin=%b irq=%b want pin=1 irq=0", out_port, irq);
    end
    tick();
    rd(2'd3, r);
    total++;
    if (r !== (exp_en | 32'h2) || irq !== exp_irq) begin
      bad++;
      $display("FAIL irq_with_done: got status=%0h irq=%b want status=%0h irq=%b",
               r, irq, exp_en | 32'h2, exp_irq);
    end
    wr(2'd3, 32'h2);
    rd(2'd3, r);
    total++;
    if (r !== 32'h0 || irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_clear: got status=%0h irq=%b want status=0 irq=0", r, irq);
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_burst();
    test_abort();
    test_races();
    test_irq();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pio_clk_gen.md
# pio_clk_gen

Avalon-MM slave that drives a serial clock pin for the touch-panel ADC interface. It generalises the single-bit output PIO: software can still hold the pin at a static level, or hand the block a hardware burst of N clock pulses at a programmable rate, instead of bit-banging every edge. It sits on the Nios II data master beside the other PIO slaves and drives one FPGA pin.

## Interface
- DIV_W, 16: width of the half-period divider register.
- CNT_W, 8: width of the burst pulse counter.
- DEFAULT_DIV, 24: reset value of DIV.
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  reset, synchronous, active-low.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address, zero wait states.
- out_port  out  1  generated clock / static level.
- irq  out  1  level interrupt, burst done.

## Operation
- A write occurs when chipselect=1 and write_n=0 at a clk edge.
- Registers:
  - addr 0, DATA: bit0 is the static level. R/W. Reads return DATA bit0, not the pin.
  - addr 1, DIV: [DIV_W-1:0]. Half-period equals DIV+1 clk cycles. R/W.
  - addr 2, BURST:
    - A write of N (bits [CNT_W-1:0]) while idle with N≠0 starts a burst of N pulses.
    - Writing N=0, or writing while busy, is ignored.
    - Reads return the remaining pulse count.
  - addr 3, STATUS:
    - bit0 busy (RO).
    - bit1 done (sticky; write 1 to clear).
    - bit2 irq_en (R/W).
    - bit3 abort (write-1 action, reads 0).
- Unused readdata bits are 0.
- FSM states are IDLE, LOW and HIGH.
  - IDLE: out_port = DATA bit0.
  - Burst start: IDLE→LOW. Load remaining = N, and load the phase counter with DIV.
  - LOW: out_port = 0. When the phase counter reaches 0, go to HIGH and reload the counter.
  - HIGH: out_port = 1. When the phase counter reaches 0:
    - Decrement remaining.
    - If remaining was 1: go to IDLE, set done.
    - Otherwise: go to LOW and reload the counter.
- The DIV value is sampled at each phase load. A DIV write mid-burst takes effect at the next phase boundary.
- DATA writes during a burst update the register. out_port reflects the new value only once the block is back in IDLE.
- Abort while busy:
  - Next state is IDLE, remaining is cleared, done is not set.
  - Abort while idle has no effect.
- Simultaneous done-set and done-clear write: set wins.
- Simultaneous abort and final HIGH-phase expiry: abort wins, done is not set.
- Reset values:
  - out_port=0, DATA=0, DIV=DEFAULT_DIV, remaining=0.
  - State IDLE, done=0, irq_en=0, irq=0.
- Reset mid-burst returns every register to its reset value at that edge.

## Timing
- Burst write at edge T:
  - busy=1 and out_port=0 from T+1.
  - Each LOW and HIGH phase lasts exactly DIV+1 cycles.
- A burst lasts exactly N·2·(DIV+1) cycles. busy drops and done rises on the same edge, at which out_port becomes DATA bit0.
- A burst with DIV=0 gives clk/2 at the pin.
- Register writes take effect at the write edge. readdata is valid in the same cycle as address.
- The abort write at edge T gives out_port=DATA bit0 and busy=0 from T+1.

## Configuration
- Macro: PIO_CLK_GEN_IRQ_EN.
- Defined: irq = done & irq_en, registered with the same timing as done. STATUS bit2 is implemented.
- Undefined:
  - irq is tied to 0.
  - STATUS bit2 reads 0 and ignores writes.
  - The port list is unchanged.

## Test plan
- Reset defaults: hold reset_n=0 for 2 cycles, then read all four addresses. Required results:
  - addr0=0, addr1=24, addr2=0, addr3=0.
  - out_port=0.
- Static mode:
  - Write DATA=1: out_port=1 on the next cycle, and reading addr0 returns 1.
  - Write DATA=0: out_port returns to 0.
- Burst: DIV=1, DATA=0, write BURST=3.
  - Pin pattern is 0,0,1,1 repeated 3 times (12 cycles).
  - busy=1 for exactly 12 cycles, then done=1.
  - Reading addr2 mid-burst returns the decrementing count 3→2→1.
- Ignored writes:
  - BURST=5 written while busy: pulse count stays 3.
  - BURST=0 written while idle: busy remains 0.
- Abort and simultaneous events, with DIV=3:
  - BURST=4, abort after 10 cycles: out_port=DATA and busy=0 next cycle, done stays 0.
  - done W1C written on the completion edge: done reads 1.
- IRQ, with PIO_CLK_GEN_IRQ_EN defined: irq_en=1, BURST=1.
  - irq rises with done.
  - Writing STATUS=0x2 clears done and irq.
  - Without the macro, irq stays 0 throughout.
